mips_run_ctrl: RTL and testbench

//  Run controller for the MIPS cores: sequences core reset, enables execution, counts cycles and retired

---
 rtl/mips_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl -- run controller for the MIPS cores.
// Holds the cores in reset for RESET_CYCLES after start, then lets them run.
// It counts RUN cycles and retired instructions, and flags a core as halted
// when that core retires the same PC HALT_REPEAT times in a row. The run ends
// in DONE when every core has halted, or in TIMEOUT after MAX_CYCLES.
// Optional build macro: RUN_CTRL_STEP_EN adds the step_mode/step inputs for
// single-step execution.
module mips_run_ctrl #(
    parameter int NUM_CORES    = 1,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int HALT_REPEAT  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CORES*PC_W-1:0] pc_i,
    input  logic [NUM_CORES-1:0]      instr_valid_i,
`ifdef RUN_CTRL_STEP_EN
    input  logic                      step_mode,
    input  logic                      step,
`endif
    output logic                      cpu_reset_o,
    output logic [NUM_CORES-1:0]      cpu_en_o,
    output logic [NUM_CORES-1:0]      halted_o,
    output logic [CNT_W-1:0]          cycle_cnt_o,
    output logic [CNT_W-1:0]          instr_cnt_o,
    output logic [2:0]                state_o,
    output logic                      done_o,
    output logic                      timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(HALT_REPEAT);

    state_e               state_q, state_d;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_q;
    logic [CNT_W-1:0]     instr_cnt_q;
    logic [NUM_CORES-1:0] halted_q;

    // Per-core halt tracker: last retired PC, repeat count, and whether any PC was seen yet.
    logic [PC_W-1:0]      last_pc_q [NUM_CORES];
    logic [REP_W-1:0]     rep_q     [NUM_CORES];
    logic [NUM_CORES-1:0] seen_q;

    logic                 run_tick;   // this RUN cycle counts as an execution cycle
    logic                 enter_rst;  // a new run starts at this edge
    logic                 cyc_inc;    // cycle counter advances at this edge
    logic [3:0]           retire_cnt;
    logic [CNT_W:0]       instr_sum;

`ifdef RUN_CTRL_STEP_EN
    assign run_tick = ~step_mode | step;
`else
    assign run_tick = 1'b1;
`endif

    // State register and reset-phase counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = '0;
        cpu_reset_o = 1'b1;
        cpu_en_o    = '0;
        done_o      = 1'b0;
        timeout_o   = 1'b0;
        enter_rst   = 1'b0;
        cyc_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RST;
                    enter_rst = 1'b1;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                cpu_reset_o = 1'b0;
                cpu_en_o    = run_tick ? ~halted_q : '0;
                // All cores halted wins over timeout and freezes the counters.
                if (&halted_q) begin
                    state_d = S_DONE;
                end else if (run_tick) begin
                    cyc_inc = 1'b1;
                    if (cycle_cnt_q == CYC_LAST) begin
                        state_d = S_TIMEOUT;
                    end
                end
            end
            S_DONE, S_TIMEOUT: begin
                cpu_reset_o = 1'b0;
                done_o      = (state_q == S_DONE);
                timeout_o   = (state_q == S_TIMEOUT);
                if (start) begin
                    state_d   = S_RST;
                    enter_rst = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Count instructions retired this cycle by enabled cores; saturate the running total.
    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire_cnt = retire_cnt + {3'b000, instr_valid_i[k] & cpu_en_o[k]};
        end
        instr_sum = {1'b0, instr_cnt_q} + (CNT_W + 1)'(retire_cnt);
    end

    // Counters, halt flags and per-core PC trackers.
    // NOTE: the tracker arrays are a handful of flops, not a RAM, so they are cleared by reset
    // like any other state; a stale seen_q or rep_q would mark a core halted too early.
    always_ff @(posedge clk) begin
        if (!reset || enter_rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            halted_q    <= '0;
            seen_q      <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                last_pc_q[k] <= '0;
                rep_q[k]     <= '0;
            end
        end else begin
            if (cyc_inc) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            instr_cnt_q <= instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];
            for (int k = 0; k < NUM_CORES; k++) begin
                if (instr_valid_i[k] && cpu_en_o[k]) begin
                    if (!seen_q[k] || (pc_i[k*PC_W +: PC_W] != last_pc_q[k])) begin
                        seen_q[k]    <= 1'b1;
                        last_pc_q[k] <= pc_i[k*PC_W +: PC_W];
                        rep_q[k]     <= REP_W'(1);
                    end else if (rep_q[k] != REP_MAX) begin
                        rep_q[k] <= rep_q[k] + REP_W'(1);
                        if (rep_q[k] == REP_MAX - REP_W'(1)) begin
                            halted_q[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign halted_o    = halted_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl -- bench for mips_run_ctrl (2 cores, 5-bit counters, MAX_CYCLES=16).
// A run-level reference model tracks the expected run phase, counters and halt
// detection using plain integers. Build with RUN_CTRL_STEP_EN to add the single-step scenario.
module tb_mips_run_ctrl;

    localparam int NC      = 2;
    localparam int PW      = 16;
    localparam int CW      = 5;
    localparam int RC      = 4;
    localparam int MAXC    = 16;
    localparam int HR      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [NC*PW-1:0]  pc    = '0;
    logic [NC-1:0]     valid = '0;
`ifdef RUN_CTRL_STEP_EN
    logic              step_mode = 1'b0;
    logic              step      = 1'b0;
`endif

    logic              cpu_reset_o;
    logic [NC-1:0]     cpu_en_o;
    logic [NC-1:0]     halted_o;
    logic [CW-1:0]     cycle_cnt_o;
    logic [CW-1:0]     instr_cnt_o;
    logic [2:0]        state_o;
    logic              done_o;
    logic              timeout_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: run phase 0..4, cycles left in reset, counters and halt trackers.
    int            m_state    = 0;
    int            m_rst_left = 0;
    int            m_cycles   = 0;
    int            m_instrs   = 0;
    logic [NC-1:0] m_halted   = '0;
    int            m_last [NC];
    int            m_rep  [NC];
    bit            m_seen [NC];

    mips_run_ctrl #(
        .NUM_CORES   (NC),
        .PC_W        (PW),
        .CNT_W       (CW),
        .RESET_CYCLES(RC),
        .MAX_CYCLES  (MAXC),
        .HALT_REPEAT (HR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pc_i         (pc),
        .instr_valid_i(valid),
`ifdef RUN_CTRL_STEP_EN
        .step_mode    (step_mode),
        .step         (step),
`endif
        .cpu_reset_o  (cpu_reset_o),
        .cpu_en_o     (cpu_en_o),
        .halted_o     (halted_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .instr_cnt_o  (instr_cnt_o),
        .state_o      (state_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic bit model_tick();
`ifdef RUN_CTRL_STEP_EN
        return !step_mode || step;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [NC-1:0] model_en();
        if (m_state == 2 && model_tick()) return ~m_halted;
        return '0;
    endfunction

    function automatic logic [19:0] model_vec();
        logic [NC-1:0] en;
        en = model_en();
        return {3'(m_state), (m_state <= 1), en, m_halted, CW'(m_cycles), CW'(m_instrs),
                (m_state == 3), (m_state == 4)};
    endfunction

    function automatic logic [19:0] act_vec();
        return {state_o, cpu_reset_o, cpu_en_o, halted_o, cycle_cnt_o, instr_cnt_o, done_o, timeout_o};
    endfunction

    task automatic model_clear();
        m_cycles = 0;
        m_instrs = 0;
        m_halted = '0;
        for (int k = 0; k < NC; k++) begin
            m_last[k] = 0;
            m_rep[k]  = 0;
            m_seen[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees at that edge.
    task automatic model_step();
        logic [NC-1:0] en;
        int            n;
        int            p;
        bit            all_halted;
        if (!reset) begin
            m_state    = 0;
            m_rst_left = 0;
            model_clear();
            return;
        end
        en = model_en();
        case (m_state)
            0: if (start) begin
                model_clear();
                m_rst_left = RC;
                m_state    = 1;
            end
            1: begin
                m_rst_left--;
                if (m_rst_left == 0) m_state = 2;
            end
            2: begin
                all_halted = &m_halted;
                n = 0;
                for (int k = 0; k < NC; k++) begin
                    if (valid[k] && en[k]) begin
                        n++;
                        p = int'(pc[k*PW +: PW]);
                        if (!m_seen[k] || p != m_last[k]) begin
                            m_seen[k] = 1;
                            m_last[k] = p;
                            m_rep[k]  = 1;
                        end else begin
                            m_rep[k]++;
                        end
                        if (m_rep[k] >= HR) m_halted[k] = 1'b1;
                    end
                end
                m_instrs = (m_instrs + n > CNT_MAX) ? CNT_MAX : m_instrs + n;
                if (all_halted) begin
                    m_state = 3;
                end else if (model_tick()) begin
                    m_cycles++;
                    if (m_cycles == MAXC) m_state = 4;
                end
            end
            3, 4: if (start) begin
                model_clear();
                m_rst_left = RC;
                m_state    = 1;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        cycle();
        checks++;
        if (act_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_vec got=%h want=%h", act_vec(), model_vec());
        end
        checks++;
        if ({state_o, cpu_reset_o, cpu_en_o, cycle_cnt_o, instr_cnt_o, done_o, timeout_o} !== {3'd0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values state=%0d rst=%b en=%b cyc=%0d ins=%0d done=%b to=%b want 0,1,00,0,0,0,0",
                     state_o, cpu_reset_o, cpu_en_o, cycle_cnt_o, instr_cnt_o, done_o, timeout_o);
        end
    endtask

    task automatic test_start_sequence();
        reset = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < RC; i++) begin
            checks++;
            if (state_o !== 3'd1 || cpu_reset_o !== 1'b1 || cpu_en_o !== 2'b00) begin
                failures++;
                $display("FAIL rst_phase[%0d] state=%0d rst=%b en=%b want 1,1,00", i, state_o, cpu_reset_o, cpu_en_o);
            end
            cycle();
        end
        checks++;
        if (state_o !== 3'd2 || cpu_reset_o !== 1'b0 || cpu_en_o !== 2'b11) begin
            failures++;
            $display("FAIL run_entry state=%0d rst=%b en=%b want 2,0,11", state_o, cpu_reset_o, cpu_en_o);
        end
        checks++;
        if (act_vec() !== model_vec()) begin
            failures++;
            $display("FAIL run_entry_vec got=%h want=%h", act_vec(), model_vec());
        end
    endtask

    task automatic test_halt_done();
        int seq [5] = '{'h3000, 'h3004, 'h3008, 'h3008, 'h3008};
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 5; i++) begin
                valid = '0;
                valid[c] = 1'b1;
                pc[c*PW +: PW] = 16'(seq[i]);
                cycle();
                checks++;
                if (act_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL halt_seq core%0d[%0d] got=%h want=%h", c, i, act_vec(), model_vec());
                end
            end
            valid = '0;
            if (c == 0) begin
                checks++;
                if (halted_o !== 2'b01 || cpu_en_o !== 2'b10) begin
                    failures++;
                    $display("FAIL halt_core0 halted=%b en=%b want 01,10", halted_o, cpu_en_o);
                end
            end
        end
        checks++;
        if (halted_o !== 2'b11 || state_o !== 3'd2) begin
            failures++;
            $display("FAIL halt_both halted=%b state=%0d want 11,2", halted_o, state_o);
        end
        cycle();
        checks++;
        if (state_o !== 3'd3 || done_o !== 1'b1 || instr_cnt_o !== 5'd10 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL done state=%0d done=%b ins=%0d to=%b want 3,1,10,0", state_o, done_o, instr_cnt_o, timeout_o);
        end
        checks++;
        if (act_vec() !== model_vec()) begin
            failures++;
            $display("FAIL done_vec got=%h want=%h", act_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (state_o !== 3'd1 || cycle_cnt_o !== 5'd0 || instr_cnt_o !== 5'd0 || halted_o !== 2'b00) begin
            failures++;
            $display("FAIL restart_clear state=%0d cyc=%0d ins=%0d halted=%b want 1,0,0,00",
                     state_o, cycle_cnt_o, instr_cnt_o, halted_o);
        end
        for (int i = 0; i < RC; i++) cycle();
        for (int i = 0; i < MAXC; i++) begin
            valid = 2'b11;
            pc[0 +: PW]  = 16'('h1000 + 4 * i);
            pc[PW +: PW] = 16'('h2000 + 4 * i);
            cycle();
            checks++;
            if (act_vec() !== model_vec()) begin
                failures++;
                $display("FAIL timeout_run[%0d] got=%h want=%h", i, act_vec(), model_vec());
            end
        end
        valid = '0;
        checks++;
        if (state_o !== 3'd4 || timeout_o !== 1'b1 || cycle_cnt_o !== 5'd16 || instr_cnt_o !== 5'd31 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout state=%0d to=%b cyc=%0d ins=%0d done=%b want 4,1,16,31,0",
                     state_o, timeout_o, cycle_cnt_o, instr_cnt_o, done_o);
        end
        cycle();
        checks++;
        if (state_o !== 3'd4 || cycle_cnt_o !== 5'd16 || cpu_en_o !== 2'b00 || cpu_reset_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_hold state=%0d cyc=%0d en=%b rst=%b want 4,16,00,0",
                     state_o, cycle_cnt_o, cpu_en_o, cpu_reset_o);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < RC; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            valid = 2'b11;
            pc[0 +: PW]  = 16'('h0400 + 4 * i);
            pc[PW +: PW] = 16'('h0800 + 4 * i);
            cycle();
            checks++;
            if (state_o !== 3'd2 || act_vec() !== model_vec()) begin
                failures++;
                $display("FAIL start_in_run[%0d] got=%h want=%h", i, act_vec(), model_vec());
            end
        end
        start = 1'b0;
        valid = '0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        checks++;
        if (state_o !== 3'd0 || cycle_cnt_o !== 5'd0 || instr_cnt_o !== 5'd0 || halted_o !== 2'b00 || cpu_reset_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run state=%0d cyc=%0d ins=%0d halted=%b rst=%b want 0,0,0,00,1",
                     state_o, cycle_cnt_o, instr_cnt_o, halted_o, cpu_reset_o);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            reset = 1'b0;
            cycle();
            reset = 1'b1;
            start = 1'b1;
            cycle();
            for (int i = 0; i < 32; i++) begin
                start = ($urandom_range(0, 7) == 0);
                reset = ($urandom_range(0, 49) != 0);
                for (int k = 0; k < NC; k++) begin
                    valid[k] = ($urandom_range(0, 9) < 7);
                    pc[k*PW +: PW] = 16'('h0100 * (k + 1) + 4 * $urandom_range(0, 1));
                end
                cycle();
                checks++;
                if (act_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL random r%0d c%0d got=%h want=%h", r, i, act_vec(), model_vec());
                end
            end
            start = 1'b0;
            reset = 1'b1;
            valid = '0;
        end
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic test_step();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        step_mode = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < RC; i++) cycle();
        for (int i = 0; i < 10; i++) begin
            step = (i == 2 || i == 5 || i == 8);
            #1;
            checks++;
            if (cpu_en_o !== (step ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL step_en[%0d] en=%b step=%b", i, cpu_en_o, step);
            end
            cycle();
        end
        step = 1'b0;
        checks++;
        if (cycle_cnt_o !== 5'd3 || state_o !== 3'd2) begin
            failures++;
            $display("FAIL step_count cyc=%0d state=%0d want 3,2", cycle_cnt_o, state_o);
        end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_start_sequence();
        test_halt_done();
        test_timeout();
        test_reset_mid_run();
        test_random();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
